// File: rtl/spline_span_calc_pkg.sv
// spline_pkg
// Shared constants and types for the spline span calculator.
// Holds the fixed-point format of the input sample, the span geometry,
// and the bundles that travel down the three pipeline stages.
// No ports (package).

package spline_pkg;

    localparam int BITSIZE = 16;
    localparam int FRAC    = 12;
    localparam int DXLOG   = 2;
    localparam int Q       = 23;
    localparam int IDXW    = 5;

    // u keeps only the bits below one span width
    localparam int UBITS   = FRAC - DXLOG;
    // Centres the span index so that x = 0 lands in the middle span
    localparam int OFFSET  = (Q - 3) / 2;

    // Width of the signed span number before clamping: the integer part of
    // x plus two bits of headroom for the offset and the sign
    localparam int TW      = BITSIZE - UBITS + 2;
    localparam logic signed [TW-1:0] T_MAX = TW'(Q - 4);

    // The powers of the local abscissa as seen by the interpolation block
    typedef struct packed {
        logic [UBITS-1:0] u;
        logic [UBITS-1:0] u2;
        logic [UBITS-1:0] u3;
    } upow_t;

    // Everything besides u that rides along with a sample through the pipe
    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            satLow;
        logic            satHigh;
        logic            valid;
    } span_tag_t;

endpackage

// File: rtl/spline_span_calc_if.sv
// spline_span_calc_if
// Bundles the sample input handshake and the span/power outputs.
//   master: drives enable, in_valid, x_in; receives the outputs
//   slave : the span calculator itself
// Signals:
//   enable    pipeline advance strobe
//   in_valid  x_in carries a real sample
//   x_in      signed input sample
//   idx_out   span index 0..Q-4
//   u_out     local abscissa in [0,1)
//   u2_out    (u*u)>>UBITS
//   u3_out    (u2*u)>>UBITS
//   sat_low   index clamped at the low end
//   sat_high  index clamped at the high end
//   out_valid outputs belong to a valid input

interface spline_span_calc_if;
    import spline_pkg::*;

    logic                enable;
    logic                in_valid;
    logic [BITSIZE-1:0]  x_in;
    logic [IDXW-1:0]     idx_out;
    logic [UBITS-1:0]    u_out;
    logic [UBITS-1:0]    u2_out;
    logic [UBITS-1:0]    u3_out;
    logic                sat_low;
    logic                sat_high;
    logic                out_valid;

    modport master (
        output enable, in_valid, x_in,
        input  idx_out, u_out, u2_out, u3_out, sat_low, sat_high, out_valid
    );

    modport slave (
        input  enable, in_valid, x_in,
        output idx_out, u_out, u2_out, u3_out, sat_low, sat_high, out_valid
    );

endinterface

// File: rtl/spline_span_calc_frac_mul_trunc.sv
// frac_mul_trunc
// Registered unsigned fractional multiply: o_p = (i_a * i_b) >> W,
// truncated. Both operands are fractions below one, so the product always
// fits back into W bits.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   i_enable    advance strobe; the register holds when low
//   i_a, i_b    W-bit unsigned fractions
//   o_p         registered truncated product

module frac_mul_trunc
    import spline_pkg::*;
#(
    parameter int W = UBITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_enable,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p
);

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   r_p;

    // Zero-extend both operands so the full double-width product is kept
    assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

    // Keep only the upper half, which is the fraction part of the product
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p <= '0;
        end else if (i_enable) begin
            r_p <= w_prod[2*W-1:W];
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/spline_span_calc.sv
// spline_span_calc
// Front end of the spline nonlinearity. Splits each sample x into a span
// index and a local abscissa u, and produces u^2 and u^3, over three
// enable-gated stages so it stays in step with the downstream delay lines.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; flushes every stage
//   bus    spline_span_calc_if slave (enable, in_valid, x_in in;
//          idx/u/u2/u3, saturation flags and out_valid out)

module spline_span_calc
    import spline_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    spline_span_calc_if.slave        bus
);

    logic signed [TW-1:0] w_t;
    logic [IDXW-1:0]      w_idx;
    logic [UBITS-1:0]     w_u;
    logic                 w_satLow;
    logic                 w_satHigh;
    logic [UBITS-1:0]     w_u2;
    logic [UBITS-1:0]     w_u3;
    upow_t                w_pow;

    span_tag_t            r_tag1;
    logic [UBITS-1:0]     r_u1;
    span_tag_t            r_tag2;
    logic [UBITS-1:0]     r_uS2;
    span_tag_t            r_tag3;
    logic [UBITS-1:0]     r_uS3;
    logic [UBITS-1:0]     r_u2S3;

    // The bits of x above the fraction are already floor(x / dx) in two's
    // complement, so sign-extending them gives the floor for negative x too
    assign w_t = {{(TW - (BITSIZE - UBITS)){bus.x_in[BITSIZE-1]}},
                  bus.x_in[BITSIZE-1:UBITS]} + TW'(OFFSET);

    // Clamp the span number into 0..Q-4; above the top span u is pinned at
    // its largest value so the curve continues from the last knot
    always_comb begin
        w_idx     = '0;
        w_u       = '0;
        w_satLow  = 1'b0;
        w_satHigh = 1'b0;
        if (w_t < 0) begin
            w_satLow  = 1'b1;
        end else if (w_t > T_MAX) begin
            w_idx     = IDXW'(Q - 4);
            w_u       = '1;
            w_satHigh = 1'b1;
        end else begin
            w_idx     = w_t[IDXW-1:0];
            w_u       = bus.x_in[UBITS-1:0];
        end
    end

    // Stage pipeline. Data loads regardless of in_valid; the valid bit
    // rides in the tag and consumers qualify with it. u^2 is registered in
    // the first multiplier alongside stage 2, u^3 in the second alongside
    // stage 3, so u2 is carried one more stage to line up with u3.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag1 <= '0;
            r_u1   <= '0;
            r_tag2 <= '0;
            r_uS2  <= '0;
            r_tag3 <= '0;
            r_uS3  <= '0;
            r_u2S3 <= '0;
        end else if (bus.enable) begin
            r_tag1 <= '{idx: w_idx, satLow: w_satLow, satHigh: w_satHigh,
                        valid: bus.in_valid};
            r_u1   <= w_u;
            r_tag2 <= r_tag1;
            r_uS2  <= r_u1;
            r_tag3 <= r_tag2;
            r_uS3  <= r_uS2;
            r_u2S3 <= w_u2;
        end
    end

    frac_mul_trunc #(.W(UBITS)) u_mulSquare (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.enable),
        .i_a      (r_u1),
        .i_b      (r_u1),
        .o_p      (w_u2)
    );

    frac_mul_trunc #(.W(UBITS)) u_mulCube (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.enable),
        .i_a      (w_u2),
        .i_b      (r_uS2),
        .o_p      (w_u3)
    );

    assign w_pow = '{u: r_uS3, u2: r_u2S3, u3: w_u3};

    assign bus.idx_out   = r_tag3.idx;
    assign bus.u_out     = w_pow.u;
    assign bus.u2_out    = w_pow.u2;
    assign bus.u3_out    = w_pow.u3;
    assign bus.sat_low   = r_tag3.satLow;
    assign bus.sat_high  = r_tag3.satHigh;
    assign bus.out_valid = r_tag3.valid;

endmodule

// File: tb/tb_spline_span_calc.sv
// tb_spline_span_calc
// Self-checking bench for spline_span_calc. A reference model computes the
// span index and powers of u with plain integer arithmetic; a queue of
// expected records models the three-enable delay from input to output.

module tb_spline_span_calc;
    import spline_pkg::*;

    localparam int SPAN = 1 << UBITS;

    typedef struct packed {
        logic [IDXW-1:0]  idx;
        logic [UBITS-1:0] u;
        logic [UBITS-1:0] u2;
        logic [UBITS-1:0] u3;
        logic             satLow;
        logic             satHigh;
        logic             valid;
    } outRec_t;

    localparam outRec_t ZERO_REC = '0;

    logic clk = 1'b0;
    logic reset;

    spline_span_calc_if bus();

    spline_span_calc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    int      nVec = 0;
    int      nErr = 0;
    outRec_t expQ[$];
    outRec_t expCur;

    // Reference: split x into floor(x/dx) and remainder, centre, clamp,
    // then form the truncated powers with integer division
    function automatic outRec_t refModel(input int x, input logic v);
        int rem, ip, t, u, u2, u3;
        outRec_t r;
        r   = '0;
        rem = ((x % SPAN) + SPAN) % SPAN;
        ip  = (x - rem) / SPAN;
        t   = ip + OFFSET;
        u   = 0;
        if (t < 0) begin
            r.satLow = 1'b1;
        end else if (t > Q - 4) begin
            t         = Q - 4;
            u         = SPAN - 1;
            r.satHigh = 1'b1;
        end else begin
            u = rem;
        end
        if (t < 0) t = 0;
        u2      = (u * u) / SPAN;
        u3      = (u2 * u) / SPAN;
        r.idx   = t[IDXW-1:0];
        r.u     = u[UBITS-1:0];
        r.u2    = u2[UBITS-1:0];
        r.u3    = u3[UBITS-1:0];
        r.valid = v;
        return r;
    endfunction

    function automatic outRec_t mkRec(input int idx, input int u, input int u2,
                                      input int u3, input logic sl,
                                      input logic sh, input logic v);
        outRec_t r;
        r.idx     = idx[IDXW-1:0];
        r.u       = u[UBITS-1:0];
        r.u2      = u2[UBITS-1:0];
        r.u3      = u3[UBITS-1:0];
        r.satLow  = sl;
        r.satHigh = sh;
        r.valid   = v;
        return r;
    endfunction

    function automatic outRec_t observed();
        outRec_t r;
        r.idx     = bus.idx_out;
        r.u       = bus.u_out;
        r.u2      = bus.u2_out;
        r.u3      = bus.u3_out;
        r.satLow  = bus.sat_low;
        r.satHigh = bus.sat_high;
        r.valid   = bus.out_valid;
        return r;
    endfunction

    function automatic string fmtRec(input outRec_t r);
        return $sformatf("idx=%0d u=%0d u2=%0d u3=%0d sl=%0b sh=%0b v=%0b",
                         r.idx, r.u, r.u2, r.u3, r.satLow, r.satHigh, r.valid);
    endfunction

    // Drive one cycle of inputs, let the clock edge pass, update the model
    // and leave time 1 unit after the edge for sampling
    task automatic stepClock(input logic en, input logic v,
                             input logic signed [BITSIZE-1:0] x,
                             input logic rst);
        reset        = rst;
        bus.enable   = en;
        bus.in_valid = v;
        bus.x_in     = x;
        @(posedge clk);
        if (rst) begin
            expQ.delete();
            expQ.push_back(ZERO_REC);
            expQ.push_back(ZERO_REC);
            expCur = ZERO_REC;
        end else if (en) begin
            expQ.push_back(refModel(int'(x), v));
            expCur = expQ.pop_front();
        end
        #1;
    endtask

    task automatic test_reset();
        outRec_t obs;
        for (int i = 0; i < 3; i++) begin
            stepClock(1'($urandom), 1'($urandom), BITSIZE'($urandom), 1'b1);
            obs = observed();
            nVec++;
            if (obs !== ZERO_REC) begin
                nErr++;
                $display("FAIL reset[%0d]: got %s, expected %s", i,
                         fmtRec(obs), fmtRec(ZERO_REC));
            end
        end
    endtask

    task automatic test_directed();
        logic signed [BITSIZE-1:0] dirX[9];
        outRec_t dirExp[9];
        outRec_t obs;
        logic signed [BITSIZE-1:0] x;
        dirX[0] = 16'sd0;      dirExp[0] = mkRec(10, 0, 0, 0, 0, 0, 1);
        dirX[1] = 16'sd1229;   dirExp[1] = mkRec(11, 205, 41, 8, 0, 0, 1);
        dirX[2] = -16'sd1229;  dirExp[2] = mkRec(8, 819, 655, 523, 0, 0, 1);
        dirX[3] = 16'sd32767;  dirExp[3] = mkRec(19, 1023, 1022, 1021, 0, 1, 1);
        dirX[4] = -16'sd32768; dirExp[4] = mkRec(0, 0, 0, 0, 1, 0, 1);
        dirX[5] = 16'sd10239;  dirExp[5] = mkRec(19, 1023, 1022, 1021, 0, 0, 1);
        dirX[6] = 16'sd10240;  dirExp[6] = mkRec(19, 1023, 1022, 1021, 0, 1, 1);
        dirX[7] = -16'sd10241; dirExp[7] = mkRec(0, 0, 0, 0, 1, 0, 1);
        dirX[8] = -16'sd1024;  dirExp[8] = mkRec(9, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 11; i++) begin
            x = (i < 9) ? dirX[i] : '0;
            stepClock(1'b1, (i < 9), x, 1'b0);
            obs = observed();
            nVec++;
            if (obs !== expCur) begin
                nErr++;
                $display("FAIL directed model[%0d]: got %s, expected %s", i,
                         fmtRec(obs), fmtRec(expCur));
            end
            if (i >= 2) begin
                nVec++;
                if (obs !== dirExp[i-2]) begin
                    nErr++;
                    $display("FAIL directed x=%0d: got %s, expected %s",
                             dirX[i-2], fmtRec(obs), fmtRec(dirExp[i-2]));
                end
            end
        end
    endtask

    task automatic test_stall();
        int      enPat[7] = '{1, 0, 0, 1, 1, 0, 1};
        outRec_t obs;
        for (int i = 0; i < 210; i++) begin
            logic en;
            if (i < 7)       en = enPat[i][0];
            else if (i < 10) en = 1'b1;
            else             en = 1'($urandom);
            stepClock(en, 1'($urandom), BITSIZE'($urandom), 1'b0);
            obs = observed();
            nVec++;
            if (obs !== expCur) begin
                nErr++;
                $display("FAIL stall[%0d] en=%0b: got %s, expected %s", i, en,
                         fmtRec(obs), fmtRec(expCur));
            end
        end
    endtask

    task automatic test_toggle();
        logic signed [BITSIZE-1:0] s[16];
        logic                      v[16];
        outRec_t                   golden;
        outRec_t                   obs;
        stepClock(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            s[k] = BITSIZE'($urandom);
            v[k] = 1'($urandom);
        end
        for (int k = 0; k < 16; k++) begin
            golden = (k >= 2) ? refModel(int'(s[k-2]), v[k-2]) : ZERO_REC;
            stepClock(1'b1, v[k], s[k], 1'b0);
            obs = observed();
            nVec++;
            if (obs !== golden) begin
                nErr++;
                $display("FAIL toggle enabled[%0d]: got %s, expected %s", k,
                         fmtRec(obs), fmtRec(golden));
            end
            stepClock(1'b0, 1'($urandom), BITSIZE'($urandom), 1'b0);
            obs = observed();
            nVec++;
            if (obs !== golden) begin
                nErr++;
                $display("FAIL toggle held[%0d]: got %s, expected %s", k,
                         fmtRec(obs), fmtRec(golden));
            end
        end
    endtask

    task automatic test_reset_midstream();
        outRec_t obs;
        for (int i = 0; i < 3; i++) begin
            stepClock(1'b1, 1'b1, BITSIZE'($urandom), 1'b0);
        end
        stepClock(1'b1, 1'b1, BITSIZE'($urandom), 1'b1);
        obs = observed();
        nVec++;
        if (obs !== ZERO_REC) begin
            nErr++;
            $display("FAIL midreset flush: got %s, expected %s",
                     fmtRec(obs), fmtRec(ZERO_REC));
        end
        for (int i = 0; i < 4; i++) begin
            stepClock(1'b1, 1'b0, BITSIZE'($urandom), 1'b0);
            obs = observed();
            nVec++;
            if (obs.valid !== 1'b0) begin
                nErr++;
                $display("FAIL midreset stale[%0d]: got out_valid=%0b, expected 0",
                         i, obs.valid);
            end
            nVec++;
            if (obs !== expCur) begin
                nErr++;
                $display("FAIL midreset model[%0d]: got %s, expected %s", i,
                         fmtRec(obs), fmtRec(expCur));
            end
        end
    endtask

    task automatic test_sweep();
        outRec_t obs;
        stepClock(1'b0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 65538; c++) begin
            stepClock(1'b1, (c < 65536), BITSIZE'(c), 1'b0);
            obs = observed();
            nVec++;
            if (obs !== expCur) begin
                nErr++;
                $display("FAIL sweep[%0d]: got %s, expected %s", c,
                         fmtRec(obs), fmtRec(expCur));
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        expQ.delete();
        expQ.push_back(ZERO_REC);
        expQ.push_back(ZERO_REC);
        expCur = ZERO_REC;

        test_reset();
        test_directed();
        test_stall();
        test_toggle();
        test_reset_midstream();
        test_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/spline_span_calc.md
Name: spline_span_calc

Overview:
- Front-end stage of the spline nonlinearity. It converts each filter-output sample x into a span index idx and a local abscissa u, and it also produces the powers u^2 and u^3.
- Its outputs feed the enable-gated N-stage delay lines, which align idx/u with the error sample for the control-point update. It also feeds the spline interpolation block.
- Pipelined over 3 stages, advancing only on enable, so it stays in lock-step with the delay lines.

Parameters:
- BITSIZE, 16: width of signed input x_in, two's complement.
- FRAC, 12: fractional bits of x_in (Q4.12 at default).
- DXLOG, 2: span width dx = 2^-DXLOG. Constraint: DXLOG < FRAC.
- Q, 23: number of control points. Must be odd and >= 5.
- IDXW, 5: width of idx_out. Must hold Q-4.
- Derived localparam UBITS = FRAC-DXLOG (10 at default): unsigned width of u, u2 and u3.
- Derived localparam OFFSET = (Q-3)/2 (10 at default).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  pipeline advance strobe, same meaning as the delay-line enable.
- in_valid  in  1  x_in carries a real sample.
- x_in  in  BITSIZE  signed input sample.
- idx_out  out  IDXW  span index, range 0..Q-4.
- u_out  out  UBITS  local abscissa u, fraction in [0,1).
- u2_out  out  UBITS  (u*u)>>UBITS.
- u3_out  out  UBITS  (u2*u)>>UBITS.
- sat_low  out  1  index was clamped at the low end.
- sat_high  out  1  index was clamped at the high end.
- out_valid  out  1  outputs correspond to a valid input.

Behaviour:
- Reset: every pipeline register and every output is 0, including out_valid, sat_low and sat_high. Reset has priority over enable. A reset mid-stream flushes all in-flight samples with no partial outputs.
- Enable: when enable=0 every register holds its value and outputs are stable. When enable=1 all stages shift by one.
- Latency: exactly 3 enabled clocks from sampling x_in to the aligned outputs. All outputs of one sample appear on the same cycle.
- Valid chain: in_valid travels through a 3-deep shift chain to out_valid. Data registers load regardless of valid; consumers qualify data with out_valid.
- Stage 1, integer and fraction split:
  - ip = x_in >>> UBITS (arithmetic shift, i.e. floor).
  - fr = x_in[UBITS-1:0], taken as unsigned.
  - t = ip + OFFSET, computed signed with at least BITSIZE-UBITS+2 bits.
- Stage 1, clamping:
  - t < 0: idx=0, u=0, sat_low=1.
  - t > Q-4: idx=Q-4, u=2^UBITS-1, sat_high=1.
  - Otherwise: idx=t, u=fr, both flags 0.
- Stage 2: u2 = (u*u)>>UBITS, truncated and never rounded. idx, u and the flags are re-registered alongside it.
- Stage 3: u3 = (u2*u)>>UBITS, truncated. Everything is registered to the outputs.
- No overflow is possible, because u < 1 keeps every product below 1.
- Boundaries:
  - x exactly on a knot gives u=0.
  - Negative x uses floor, not truncation toward zero.
  - t = Q-4 exactly is not saturated.
  - enable toggling every cycle must produce the same output sequence as continuous enable.

Decomposition:
- Shared package spline_pkg holds:
  - Q, DXLOG, FRAC, OFFSET, UBITS, IDXW.
  - The u-power bundle type: u, u2, u3.
- One natural sub-module, frac_mul_trunc: a registered UBITSxUBITS unsigned multiply with >>UBITS truncation and enable/reset. It is instantiated twice, for stages 2 and 3.

Test Plan:
- x=0 (0x0000) with in_valid=1 and enable held high: after 3 clocks, idx=10, u=u2=u3=0, out_valid=1, no sat flags.
- x=1229 (~0.300): idx=11, u=205, u2=41, u3=8. Then x=-1229: idx=8, u=819, u2=655, u3=523. Confirms floor on negative input.
- Saturation:
  - x=32767: idx=19, u=1023, u2=1022, u3=1021, sat_high=1.
  - x=-32768: idx=0, u=u2=u3=0, sat_low=1.
- Stall: feed 4 samples with enable pattern 1,0,0,1,1,0,1 and random in_valid. The output sequence and out_valid must match the continuous-enable golden model, with outputs frozen while enable=0.
- Reset mid-stream: assert reset for 1 clock while 3 valid samples are in flight. All outputs and out_valid go 0 on the next cycle, and no stale sample emerges afterward.
- Exhaustive sweep of x over all 65536 codes against a reference model: idx, u, u2, u3 and flags match bit-exactly.
